ysyx_22050039_mexu: RTL and testbench
=====================================

# ysyx_22050039_mexu

Multi-cycle execute unit for the ysyx_22050039 core, generalising the single-cycle integer execute stage to XLEN-parametrised ALU, multiply and divide operations, with 32-bit word-mode variants. Sits between decode and writeback behind valid/ready handshakes on both sides. ALU ops complete in one cycle; MUL/DIV iterate bit-serially and backpressure decode while busy.

## Interface
- XLEN, 64, datapath width; legal values ≥ 32.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-low.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit can accept; high only in IDLE.
- op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL, 11 MULH, 12 DIV, 13 DIVU, 14 REM, 15 REMU.
- word  in  1  32-bit variant; ignored for AND/OR/XOR/SLT/SLTU/MULH.
- src1, src2  in  XLEN  operands.
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts result.
- result  out  XLEN  operation result; stable while out_valid && !out_ready.
- illegal  out  1  pulses with out_valid when op is DIV..REMU and the divider is compiled out.

## Operation
- States: IDLE, MUL, DIV, DONE. Accept = in_valid && in_ready; operands, op, word latched on accept.
- IDLE→DONE on accept of ops 0–9 (result computed combinationally from inputs, registered into result).
- IDLE→MUL on ops 10–11; IDLE→DIV on ops 12–15; IDLE→DONE on ops 12–15 if divider compiled out.
- MUL: shift-add, one multiplier bit per cycle, 2·XLEN accumulator; MULH returns signed×signed high XLEN bits (magnitudes multiplied, sign fixed at end). MUL returns low XLEN bits.
- DIV: restoring, one quotient bit per cycle on magnitudes; signs applied at end (quotient negative iff signs differ, remainder takes dividend sign).
- Iteration count N = 32 if word else XLEN; counter loads N on entry, decrements per cycle, MUL/DIV→DONE when it reaches 1 (result registered that cycle).
- DONE: out_valid=1; DONE→IDLE when out_ready. No accept while in DONE.
- Shifts: amount = src2[5:0] (XLEN=64) / src2[$clog2(XLEN)-1:0]; word mode uses src2[4:0] on src1[31:0].
- Word mode: operands truncated to 32 bits (sign-extended for signed ops, zero-extended for unsigned); result[31:0] sign-extended to XLEN.
- Divide by zero: quotient = all ones, remainder = dividend. Signed overflow (most-negative ÷ −1): quotient = dividend, remainder = 0. Both still take N cycles.
- SLT/SLTU: result = 0 or 1.

## Timing
- Reset (rst=0 at posedge): state IDLE, out_valid=0, result=0, illegal=0, counter=0; in_ready=1 from the following cycle. Reset mid-MUL/DIV abandons the operation with no output.
- ALU op accepted at posedge k: out_valid at k+1.
- MUL/DIV op accepted at k: out_valid at k+N (k+64 for XLEN=64, k+32 word).
- Result held and out_valid stays high until out_ready; in_ready rises the cycle after handshake (no same-cycle back-to-back; max ALU throughput one op per 2 cycles).
- in_valid while busy is ignored; producer must hold it.

## Configuration
- YSYX_22050039_DIV_EN defined: divider datapath present; ops 12–15 behave as above, illegal never asserts.
- Undefined: no divider logic; ops 12–15 go IDLE→DONE in 1 cycle with result=0 and illegal=1 for the DONE cycles.

## Test plan
- Reset: hold rst=0 two cycles mid-MUL -> out_valid=0, result=0, in_ready=1 next cycle, no stale result later.
- ADD 0x7FFF_FFFF + 1, word=1 -> out_valid one cycle after accept, result=0xFFFF_FFFF_8000_0000.
- MULH src1=−1, src2=−1 (XLEN=64) -> result=0 at accept+64; MUL same operands -> result=1.
- DIV src1=0x8000_0000_0000_0000, src2=−1 -> quotient 0x8000_0000_0000_0000; REM -> 0; DIVU 7÷0 -> 0xFFFF_FFFF_FFFF_FFFF; REMU 7÷0 -> 7.
- Backpressure: SUB 5−7 with out_ready=0 for 5 cycles -> result=0xFFFF_FFFF_FFFF_FFFE held stable, in_ready=0 throughout, in_ready=1 cycle after out_ready.
- Macro off: DIV 10÷2 -> out_valid at accept+1, result=0, illegal=1.

Source files
------------

// File: rtl/ysyx_22050039_mexu_if.sv
// Decode/writeback handshake bundle for the multi-cycle execute unit.
// master = producer/consumer side, slave = execute unit.
interface ysyx_22050039_mexu_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      op;
  logic            word;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            illegal;

  modport master (
    output in_valid, op, word, src1, src2, out_ready,
    input  in_ready, out_valid, result, illegal
  );
  modport slave (
    input  in_valid, op, word, src1, src2, out_ready,
    output in_ready, out_valid, result, illegal
  );
endinterface

// File: rtl/ysyx_22050039_mexu.sv
// Multi-cycle execute unit: single-cycle ALU, bit-serial shift-add multiplier, restoring divider.
// Define YSYX_22050039_DIV_EN to build the divider; otherwise ops 12-15 finish at once with result 0 and illegal set.
module ysyx_22050039_mexu #(
  parameter int XLEN = 64
) (
  input logic                clk,
  input logic                rst,
  ysyx_22050039_mexu_if.slave io
);
  localparam int SH = $clog2(XLEN);
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [1:0] S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                         OP_XOR = 4'd4, OP_SLL = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
                         OP_SLT = 4'd8, OP_SLTU = 4'd9, OP_MUL = 4'd10, OP_MULH = 4'd11,
                         OP_DIV = 4'd12, OP_DIVU = 4'd13;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
    return XLEN'($signed(x));
  endfunction

  logic [1:0]        state_q, state_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic              ill_q, ill_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [3:0]        op_q, op_d;
  logic              word_q, word_d, neg_q, neg_d;
  logic [2*XLEN-1:0] acc_q, acc_d, mc_q, mc_d;
  logic [XLEN-1:0]   mp_q, mp_d;

  // Operand conditioning: word truncation then sign/zero extension, then magnitudes
  logic            wmode, sgn_op, a_neg, b_neg;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag;
  assign wmode  = io.word && !(io.op inside {OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLTU, OP_MULH});
  assign sgn_op = !(io.op inside {OP_DIVU, 4'd15});
  assign a_ext  = !wmode ? io.src1 : (sgn_op ? sext32(io.src1[31:0]) : XLEN'(io.src1[31:0]));
  assign b_ext  = !wmode ? io.src2 : (sgn_op ? sext32(io.src2[31:0]) : XLEN'(io.src2[31:0]));
  assign a_neg  = sgn_op && a_ext[XLEN-1];
  assign b_neg  = sgn_op && b_ext[XLEN-1];
  assign a_mag  = a_neg ? -a_ext : a_ext;
  assign b_mag  = b_neg ? -b_ext : b_ext;

  logic [XLEN-1:0] alu;
  logic [31:0]     alu32;
  always_comb begin
    alu   = '0;
    alu32 = '0;
    case (io.op)
      OP_ADD:  begin alu = io.src1 + io.src2; alu32 = io.src1[31:0] + io.src2[31:0]; end
      OP_SUB:  begin alu = io.src1 - io.src2; alu32 = io.src1[31:0] - io.src2[31:0]; end
      OP_AND:  alu = io.src1 & io.src2;
      OP_OR:   alu = io.src1 | io.src2;
      OP_XOR:  alu = io.src1 ^ io.src2;
      OP_SLL:  begin alu = io.src1 << io.src2[SH-1:0]; alu32 = io.src1[31:0] << io.src2[4:0]; end
      OP_SRL:  begin alu = io.src1 >> io.src2[SH-1:0]; alu32 = io.src1[31:0] >> io.src2[4:0]; end
      OP_SRA:  begin
        alu   = XLEN'($signed(io.src1) >>> io.src2[SH-1:0]);
        alu32 = 32'($signed(io.src1[31:0]) >>> io.src2[4:0]);
      end
      OP_SLT:  alu = XLEN'($signed(io.src1) < $signed(io.src2));
      OP_SLTU: alu = XLEN'(io.src1 < io.src2);
      default: ;
    endcase
    if (wmode) alu = sext32(alu32);
  end

  // The first iteration runs on the accept edge, so IDLE feeds fresh magnitudes into the step
  logic [2*XLEN-1:0] m_acc, m_mc, m_acc_n, prod;
  logic [XLEN-1:0]   m_mp, mul_res;
  always_comb begin
    if (state_q == S_IDLE) begin
      m_acc = '0;
      m_mc  = (2*XLEN)'(a_mag);
      m_mp  = b_mag;
    end else begin
      m_acc = acc_q;
      m_mc  = mc_q;
      m_mp  = mp_q;
    end
    m_acc_n = m_acc + (m_mp[0] ? m_mc : '0);
    prod    = neg_q ? -m_acc_n : m_acc_n;
    mul_res = (op_q == OP_MULH) ? prod[2*XLEN-1:XLEN] :
              (word_q ? sext32(prod[31:0]) : prod[XLEN-1:0]);
  end

`ifdef YSYX_22050039_DIV_EN
  logic            sa_q, sa_d, dz_q, dz_d;
  logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dsr_q, dsr_d;
  logic [XLEN-1:0] d_rem, d_quo, d_dsr, d_rem_n, d_quo_n, d_q, d_r, d_v, div_res;
  logic [XLEN:0]   d_tmp, d_diff;
  always_comb begin
    if (state_q == S_IDLE) begin
      d_rem = '0;
      d_quo = wmode ? (a_mag << (XLEN - 32)) : a_mag;
      d_dsr = b_mag;
    end else begin
      d_rem = rem_q;
      d_quo = quo_q;
      d_dsr = dsr_q;
    end
    d_tmp   = {d_rem, d_quo[XLEN-1]};
    d_diff  = d_tmp - {1'b0, d_dsr};
    d_rem_n = d_diff[XLEN] ? d_tmp[XLEN-1:0] : d_diff[XLEN-1:0];
    d_quo_n = {d_quo[XLEN-2:0], !d_diff[XLEN]};
    // A zero divisor already leaves the dividend in the remainder; only the quotient is forced
    d_q     = dz_q ? '1 : (neg_q ? -d_quo_n : d_quo_n);
    d_r     = sa_q ? -d_rem_n : d_rem_n;
    d_v     = (op_q inside {OP_DIV, OP_DIVU}) ? d_q : d_r;
    div_res = word_q ? sext32(d_v[31:0]) : d_v;
  end
`endif

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    ill_d   = ill_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    word_d  = word_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    mc_d    = mc_q;
    mp_d    = mp_q;
`ifdef YSYX_22050039_DIV_EN
    sa_d    = sa_q;
    dz_d    = dz_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dsr_d   = dsr_q;
`endif
    case (state_q)
      S_IDLE: if (io.in_valid) begin
        op_d   = io.op;
        word_d = wmode;
        neg_d  = a_neg ^ b_neg;
        cnt_d  = wmode ? CW'(32) : CW'(XLEN);
        acc_d  = m_acc_n;
        mc_d   = m_mc << 1;
        mp_d   = m_mp >> 1;
`ifdef YSYX_22050039_DIV_EN
        sa_d   = a_neg;
        dz_d   = (b_mag == '0);
        rem_d  = d_rem_n;
        quo_d  = d_quo_n;
        dsr_d  = d_dsr;
`endif
        if (io.op inside {OP_MUL, OP_MULH}) state_d = S_MUL;
        else if (io.op >= OP_DIV) begin
`ifdef YSYX_22050039_DIV_EN
          state_d = S_DIV;
`else
          state_d = S_DONE;
          res_d   = '0;
          ill_d   = 1'b1;
`endif
        end else begin
          state_d = S_DONE;
          res_d   = alu;
        end
      end
      S_MUL: begin
        cnt_d = cnt_q - CW'(1);
        acc_d = m_acc_n;
        mc_d  = m_mc << 1;
        mp_d  = m_mp >> 1;
        if (cnt_q == CW'(2)) begin
          state_d = S_DONE;
          res_d   = mul_res;
        end
      end
      S_DIV: begin
`ifdef YSYX_22050039_DIV_EN
        cnt_d = cnt_q - CW'(1);
        rem_d = d_rem_n;
        quo_d = d_quo_n;
        if (cnt_q == CW'(2)) begin
          state_d = S_DONE;
          res_d   = div_res;
        end
`else
        state_d = S_IDLE;
`endif
      end
      S_DONE: if (io.out_ready) begin
        state_d = S_IDLE;
        ill_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      res_q   <= '0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
      op_q    <= '0;
      word_q  <= 1'b0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      mc_q    <= '0;
      mp_q    <= '0;
`ifdef YSYX_22050039_DIV_EN
      sa_q    <= 1'b0;
      dz_q    <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      dsr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      word_q  <= word_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      mc_q    <= mc_d;
      mp_q    <= mp_d;
`ifdef YSYX_22050039_DIV_EN
      sa_q    <= sa_d;
      dz_q    <= dz_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dsr_q   <= dsr_d;
`endif
    end
  end

  assign io.in_ready  = (state_q == S_IDLE);
  assign io.out_valid = (state_q == S_DONE);
  assign io.result    = res_q;
  assign io.illegal   = ill_q;
endmodule

// File: tb/tb_ysyx_22050039_mexu.sv
// Bench for ysyx_22050039_mexu: directed vector table, hand-written reset/backpressure
// sequences and random ops checked against an arithmetic reference model.
module tb_ysyx_22050039_mexu;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ysyx_22050039_mexu_if #(.XLEN(64)) bus ();
  ysyx_22050039_mexu #(.XLEN(64)) dut (.clk(clk), .rst(rst), .io(bus));

  int checks = 0;
  int errors = 0;
  localparam longint MINL = 64'sh8000_0000_0000_0000;
  localparam int MIN32 = 32'sh8000_0000;

  typedef struct {
    logic [3:0]  op;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    int          hold;
    logic [63:0] res;
    int          lat;
  } vec_t;
  vec_t vt[21];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: result computed straight from the ISA-level rules
  function automatic logic [64:0] model(input logic [3:0] op, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r; logic [31:0] r32; logic signed [127:0] p;
    longint x, y; int x32, y32; logic ill;
    x = a; y = b; x32 = a[31:0]; y32 = b[31:0];
    r = '0; r32 = '0; p = '0; ill = 1'b0;
    case (op)
      4'd0:  begin r = a + b; r32 = a[31:0] + b[31:0]; end
      4'd1:  begin r = a - b; r32 = a[31:0] - b[31:0]; end
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  begin r = a << b[5:0]; r32 = a[31:0] << b[4:0]; end
      4'd6:  begin r = a >> b[5:0]; r32 = a[31:0] >> b[4:0]; end
      4'd7:  begin r = x >>> b[5:0]; r32 = x32 >>> b[4:0]; end
      4'd8:  r = (x < y) ? 64'd1 : 64'd0;
      4'd9:  r = (a < b) ? 64'd1 : 64'd0;
      4'd10: begin r = a * b; r32 = a[31:0] * b[31:0]; end
      4'd11: begin p = $signed(x) * $signed(y); r = p[127:64]; end
      4'd12: begin
        if (y == 0) r = '1; else if (x == MINL && y == -1) r = a; else r = x / y;
        if (y32 == 0) r32 = '1; else if (x32 == MIN32 && y32 == -1) r32 = a[31:0]; else r32 = x32 / y32;
      end
      4'd13: begin
        if (b == 0) r = '1; else r = a / b;
        if (b[31:0] == 0) r32 = '1; else r32 = a[31:0] / b[31:0];
      end
      4'd14: begin
        if (y == 0) r = a; else if (x == MINL && y == -1) r = 0; else r = x % y;
        if (y32 == 0) r32 = a[31:0]; else if (x32 == MIN32 && y32 == -1) r32 = 0; else r32 = x32 % y32;
      end
      default: begin
        if (b == 0) r = a; else r = a % b;
        if (b[31:0] == 0) r32 = a[31:0]; else r32 = a[31:0] % b[31:0];
      end
    endcase
    if (w && !(op inside {4'd2, 4'd3, 4'd4, 4'd8, 4'd9, 4'd11})) r = {{32{r32[31]}}, r32};
`ifndef YSYX_22050039_DIV_EN
    if (op >= 4'd12) begin r = '0; ill = 1'b1; end
`endif
    return {ill, r};
  endfunction

  function automatic int exp_lat(input logic [3:0] op, input logic w);
    if (op >= 4'd12) begin
`ifdef YSYX_22050039_DIV_EN
      return w ? 32 : 64;
`else
      return 1;
`endif
    end
    if (op == 4'd10) return w ? 32 : 64;
    if (op == 4'd11) return 64;
    return 1;
  endfunction

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'($urandom_range(0, 20));
      4: return {$urandom, 32'h8000_0000};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Offer one op, wait for the result, hold out_ready low for 'hold' cycles, then drain
  task automatic do_op(input logic [3:0] op, input logic w, input logic [63:0] a, input logic [63:0] b,
                       input int hold, output logic [63:0] res, output logic ill, output int lat,
                       output logic stable, output logic rdy_after);
    int g;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = op; bus.word = w; bus.src1 = a; bus.src2 = b;
    g = 0;
    while (!bus.in_ready && g < 100) begin @(negedge clk); g++; end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.op = 4'($urandom); bus.word = 1'($urandom);
    bus.src1 = {$urandom, $urandom}; bus.src2 = {$urandom, $urandom};
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.out_valid && lat < 200);
    res = bus.result; ill = bus.illegal; stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!bus.out_valid || bus.result !== res || bus.in_ready || bus.illegal !== ill) stable = 1'b0;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    rdy_after = bus.in_ready && !bus.out_valid;
  endtask

  task automatic check_op(input string name, input logic [3:0] op, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input int hold, input logic [63:0] e_res,
                          input logic e_ill, input int e_lat);
    logic [63:0] res; logic ill, st, ra; int lat;
    do_op(op, w, a, b, hold, res, ill, lat, st, ra);
    chk({name, " result"}, res, e_res);
    chk({name, " illegal"}, 64'(ill), 64'(e_ill));
    chk({name, " latency"}, 64'(lat), 64'(e_lat));
    if (hold > 0) chk({name, " held"}, 64'(st), 64'd1);
    chk({name, " in_ready after"}, 64'(ra), 64'd1);
  endtask

  initial begin
    logic [3:0] op; logic w; logic [63:0] a, b, e_res; logic [64:0] m; logic e_ill, stale; int e_lat;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op = '0; bus.word = 1'b0;
    bus.src1 = '0; bus.src2 = '0;

    vt[0]  = '{4'd0,  1'b1, 64'h7FFF_FFFF, 64'd1, 0, 64'hFFFF_FFFF_8000_0000, 1};
    vt[1]  = '{4'd1,  1'b0, 64'd5, 64'd7, 5, 64'hFFFF_FFFF_FFFF_FFFE, 1};
    vt[2]  = '{4'd11, 1'b0, '1, '1, 0, 64'd0, 64};
    vt[3]  = '{4'd10, 1'b0, '1, '1, 0, 64'd1, 64};
    vt[4]  = '{4'd12, 1'b0, 64'h8000_0000_0000_0000, '1, 0, 64'h8000_0000_0000_0000, 64};
    vt[5]  = '{4'd14, 1'b0, 64'h8000_0000_0000_0000, '1, 0, 64'd0, 64};
    vt[6]  = '{4'd13, 1'b0, 64'd7, 64'd0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64};
    vt[7]  = '{4'd15, 1'b0, 64'd7, 64'd0, 0, 64'd7, 64};
    vt[8]  = '{4'd12, 1'b0, 64'd10, 64'd2, 0, 64'd5, 64};
    vt[9]  = '{4'd8,  1'b0, '1, 64'd1, 0, 64'd1, 1};
    vt[10] = '{4'd9,  1'b0, '1, 64'd1, 0, 64'd0, 1};
    vt[11] = '{4'd7,  1'b1, 64'h8000_0000, 64'd4, 0, 64'hFFFF_FFFF_F800_0000, 1};
    vt[12] = '{4'd6,  1'b0, 64'h8000_0000_0000_0000, 64'h1FF, 0, 64'd1, 1};
    vt[13] = '{4'd10, 1'b1, 64'hFFFF_0000_1234_5678, 64'h10, 0, 64'h0000_0000_2345_6780, 32};
    vt[14] = '{4'd12, 1'b1, 64'hFFFF_FFF9, 64'd2, 0, 64'hFFFF_FFFF_FFFF_FFFD, 32};
    vt[15] = '{4'd14, 1'b1, 64'hFFFF_FFF9, 64'd2, 0, 64'hFFFF_FFFF_FFFF_FFFF, 32};
    vt[16] = '{4'd14, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 0, 64'hFFFF_FFFF_FFFF_FFFB, 64};
    vt[17] = '{4'd11, 1'b1, 64'h4000_0000_0000_0000, 64'd4, 0, 64'd1, 64};
    vt[18] = '{4'd4,  1'b1, 64'hF0F0_F0F0_F0F0_F0F0, '1, 0, 64'h0F0F_0F0F_0F0F_0F0F, 1};
    vt[19] = '{4'd5,  1'b1, 64'd1, 64'd31, 0, 64'hFFFF_FFFF_8000_0000, 1};
    vt[20] = '{4'd5,  1'b0, 64'd1, 64'd63, 0, 64'h8000_0000_0000_0000, 1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset result", bus.result, 64'd0);
    chk("reset illegal", 64'(bus.illegal), 64'd0);
    chk("reset in_ready", 64'(bus.in_ready), 64'd1);
    rst = 1'b1;

    foreach (vt[i]) begin
      e_res = vt[i].res; e_lat = vt[i].lat; e_ill = 1'b0;
`ifndef YSYX_22050039_DIV_EN
      if (vt[i].op >= 4'd12) begin e_res = '0; e_lat = 1; e_ill = 1'b1; end
`endif
      check_op($sformatf("vec%0d", i), vt[i].op, vt[i].w, vt[i].a, vt[i].b, vt[i].hold, e_res, e_ill, e_lat);
    end

    // Reset in the middle of a multiply abandons it
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = 4'd10; bus.word = 1'b0; bus.src1 = 64'd3; bus.src2 = 64'd5;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midrst out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst result", bus.result, 64'd0);
    chk("midrst in_ready", 64'(bus.in_ready), 64'd1);
    rst = 1'b1;
    stale = 1'b0;
    repeat (80) begin @(negedge clk); if (bus.out_valid) stale = 1'b1; end
    chk("midrst no stale result", 64'(stale), 64'd0);

    for (int i = 0; i < 120; i++) begin
      op = 4'($urandom_range(0, 15)); w = 1'($urandom_range(0, 1));
      a = rnd64(); b = rnd64();
      m = model(op, w, a, b);
      check_op($sformatf("rand%0d op%0d w%0d a=%h b=%h", i, op, w, a, b), op, w, a, b,
               int'($urandom_range(0, 2)), m[63:0], m[64], exp_lat(op, w));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
